mem_port_arbiter: RTL and testbench

Two-port arbiter sharing the layer's single-ported memory between the MBus layer controller (port 0) and a local requester such as a core or DMA engine (port 1). It forwards one four-phase REQ/ACK transaction at a time to the memory port and registers the address, write data and read data. It aborts a stalled access with a watchdog timeout and reports the error to the requester. It sits between the requesters and the memory macro's MEM_REQ_OUT/MEM_ACK_IN interface.

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between two four-phase REQ/ACK requesters
// (port 0: MBus layer controller, port 1: local core/DMA). One transaction is
// forwarded at a time. Address, write data and read data are registered. A
// watchdog aborts an access that the memory never acknowledges and reports it
// through ERRn.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin on a tie (port 0 first)
//                           undefined -> fixed priority, port 0 wins a tie
//
// Parameters:
//   ADDR_W       word-address width
//   DATA_W       data width
//   TIMEOUT_CYC  ISSUE cycles without MEM_ACK_IN before abort (0 = never)
//
// Ports:
//   CLK, MEM_ACK_RSTn      clock (posedge), async active-low reset
//   REQn/WRn/ADDRn/WDATAn  requester side inputs, n = 0/1
//   ACKn/ERRn              requester completion / timeout flag
//   RDATA                  last read data
//   GRANT                  port owning the current or last transaction
//   BUSY                   arbiter not in IDLE
//   MEM_REQ_OUT/MEM_WRITE/MEM_AOUT/MEM_DOUT   memory request side
//   MEM_ACK_IN/MEM_DIN     memory acknowledge and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W      = 30,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              CLK,
   input  logic              MEM_ACK_RSTn,
   input  logic              REQ0,
   input  logic              REQ1,
   input  logic              WR0,
   input  logic              WR1,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [DATA_W-1:0] WDATA0,
   input  logic [DATA_W-1:0] WDATA1,
   output logic              ACK0,
   output logic              ACK1,
   output logic              ERR0,
   output logic              ERR1,
   output logic [DATA_W-1:0] RDATA,
   output logic              GRANT,
   output logic              BUSY,
   output logic              MEM_REQ_OUT,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_AOUT,
   output logic [DATA_W-1:0] MEM_DOUT,
   input  logic              MEM_ACK_IN,
   input  logic [DATA_W-1:0] MEM_DIN
);

   localparam int TMR_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYC == 0) ? '0 : TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_SAT  = '1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_REPLY} state_t;

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_ack, w_ack_nxt;
   logic [1:0]          r_err, w_err_nxt;
   logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
   logic                r_grant, w_grant_nxt;
   logic                r_busy, w_busy_nxt;
   logic                r_mem_req, w_mem_req_nxt;
   logic                r_mem_write, w_mem_write_nxt;
   logic [ADDR_W-1:0]   r_mem_aout, w_mem_aout_nxt;
   logic [DATA_W-1:0]   r_mem_dout, w_mem_dout_nxt;
   logic [TMR_W-1:0]    r_timer, w_timer_nxt;

   logic [1:0]          w_elig;
   logic                w_winner;
   logic                w_req_granted;

   // A port may compete only while it has no completion still pending.
   assign w_elig        = {REQ1 & ~r_ack[1], REQ0 & ~r_ack[0]};
   assign w_req_granted = r_grant ? REQ1 : REQ0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // r_rr_ptr holds the port that wins the next tie; it always points away
   // from the port granted last.
   logic r_rr_ptr, w_rr_ptr_nxt;
   assign w_winner = (&w_elig) ? r_rr_ptr : w_elig[1];
`else
   assign w_winner = ~w_elig[0];
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_ack_nxt       = r_ack;
      w_err_nxt       = r_err;
      w_rdata_nxt     = r_rdata;
      w_grant_nxt     = r_grant;
      w_mem_req_nxt   = r_mem_req;
      w_mem_write_nxt = r_mem_write;
      w_mem_aout_nxt  = r_mem_aout;
      w_mem_dout_nxt  = r_mem_dout;
      w_timer_nxt     = r_timer;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w_rr_ptr_nxt    = r_rr_ptr;
`endif
      case (r_state)
         S_IDLE: begin
            // Holding off while MEM_ACK_IN is high absorbs a late ack that
            // belongs to an access already aborted by the watchdog.
            if (!MEM_ACK_IN && (|w_elig)) begin
               w_grant_nxt     = w_winner;
               w_mem_aout_nxt  = w_winner ? ADDR1  : ADDR0;
               w_mem_write_nxt = w_winner ? WR1    : WR0;
               w_mem_dout_nxt  = w_winner ? WDATA1 : WDATA0;
               w_mem_req_nxt   = 1'b1;
               w_timer_nxt     = '0;
               w_state_nxt     = S_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               w_rr_ptr_nxt    = ~w_winner;
`endif
            end
         end
         S_ISSUE: begin
            if (MEM_ACK_IN) begin
               w_mem_req_nxt = 1'b0;
               if (!r_mem_write) w_rdata_nxt = MEM_DIN;
               w_state_nxt   = S_DRAIN;
            end else if ((TIMEOUT_CYC != 0) && (r_timer == TMR_LAST)) begin
               w_mem_req_nxt      = 1'b0;
               w_ack_nxt[r_grant] = 1'b1;
               w_err_nxt[r_grant] = 1'b1;
               w_state_nxt        = S_REPLY;
            end else if (r_timer != TMR_SAT) begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         S_DRAIN: begin
            if (!MEM_ACK_IN) begin
               w_ack_nxt[r_grant] = 1'b1;
               w_state_nxt        = S_REPLY;
            end
         end
         S_REPLY: begin
            if (!w_req_granted) begin
               w_ack_nxt   = 2'b00;
               w_err_nxt   = 2'b00;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge CLK or negedge MEM_ACK_RSTn) begin
      if (!MEM_ACK_RSTn) r_state <= S_IDLE;
      else               r_state <= w_state_nxt;
   end

   // Every output is a flop; reset abandons any in-flight access.
   always_ff @(posedge CLK or negedge MEM_ACK_RSTn) begin
      if (!MEM_ACK_RSTn) begin
         r_ack       <= '0;
         r_err       <= '0;
         r_rdata     <= '0;
         r_grant     <= 1'b0;
         r_busy      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_aout  <= '0;
         r_mem_dout  <= '0;
         r_timer     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         r_rr_ptr    <= 1'b0;
`endif
      end else begin
         r_ack       <= w_ack_nxt;
         r_err       <= w_err_nxt;
         r_rdata     <= w_rdata_nxt;
         r_grant     <= w_grant_nxt;
         r_busy      <= w_busy_nxt;
         r_mem_req   <= w_mem_req_nxt;
         r_mem_write <= w_mem_write_nxt;
         r_mem_aout  <= w_mem_aout_nxt;
         r_mem_dout  <= w_mem_dout_nxt;
         r_timer     <= w_timer_nxt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         r_rr_ptr    <= w_rr_ptr_nxt;
`endif
      end
   end

   assign ACK0        = r_ack[0];
   assign ACK1        = r_ack[1];
   assign ERR0        = r_err[0];
   assign ERR1        = r_err[1];
   assign RDATA       = r_rdata;
   assign GRANT       = r_grant;
   assign BUSY        = r_busy;
   assign MEM_REQ_OUT = r_mem_req;
   assign MEM_WRITE   = r_mem_write;
   assign MEM_AOUT    = r_mem_aout;
   assign MEM_DOUT    = r_mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter. The stimulus side describes batches
// of per-port transactions; a reference model predicts the order in which the
// arbiter serves them and the response of each one, and pushes those into a
// queue. A monitor pops an entry whenever an ACK rises and compares. A
// behavioural memory answers MEM_REQ_OUT with random latency.
// Honours MEM_ARB_ROUND_ROBIN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   localparam int AW = 30;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          CLK = 1'b0;
   logic          rstn;
   logic          req0, req1, wr0, wr1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wd0, wd1;
   logic          ack0, ack1, err0, err1, grant, busy;
   logic [DW-1:0] rdata;
   logic          mreq, mwr, mack;
   logic [AW-1:0] maout;
   logic [DW-1:0] mdout, mdin;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .CLK(CLK), .MEM_ACK_RSTn(rstn),
      .REQ0(req0), .REQ1(req1), .WR0(wr0), .WR1(wr1),
      .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wd0), .WDATA1(wd1),
      .ACK0(ack0), .ACK1(ack1), .ERR0(err0), .ERR1(err1),
      .RDATA(rdata), .GRANT(grant), .BUSY(busy),
      .MEM_REQ_OUT(mreq), .MEM_WRITE(mwr), .MEM_AOUT(maout), .MEM_DOUT(mdout),
      .MEM_ACK_IN(mack), .MEM_DIN(mdin)
   );

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      bit            drop;
   } txn_t;

   typedef struct {
      int            port;
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wd;
      logic [DW-1:0] rd;
      bit            err;
      bit            drop;
   } exp_t;

   exp_t sb[$];
   txn_t pq0[$], pq1[$];

   // reference model state
   logic [DW-1:0] m_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   bit m_pref;
`endif

   // memory model controls
   bit            mem_silent;
   int            lat_min, lat_max;
   bit            ovr_en;
   logic [DW-1:0] ovr_val;
   int            pulse_req_cnt;
   logic [AW-1:0] mw_addr;
   logic [DW-1:0] mw_data;

   int n_cmp, n_fail;

   function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
      return ({2'b00, a} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // Reference: replay the arbitration rules over the two request lists.
   task automatic predict(input bit silent);
      int   i0, i1, w;
      txn_t t;
      exp_t e;
      i0 = 0;
      i1 = 0;
      while (i0 < pq0.size() || i1 < pq1.size()) begin
         if (i0 < pq0.size() && i1 < pq1.size()) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = m_pref ? 1 : 0;
`else
            w = 0;
`endif
         end else begin
            w = (i0 < pq0.size()) ? 0 : 1;
         end
`ifdef MEM_ARB_ROUND_ROBIN_EN
         m_pref = (w == 0);
`endif
         if (w == 0) begin t = pq0[i0]; i0++; end
         else        begin t = pq1[i1]; i1++; end
         e.port = w; e.wr = t.wr; e.addr = t.addr; e.wd = t.wd;
         e.drop = t.drop; e.err = silent;
         if (!silent && !t.wr) m_rdata = ovr_en ? ovr_val : hash(t.addr);
         e.rd = m_rdata;
         sb.push_back(e);
      end
   endtask

   task automatic drive_port(input int p, input txn_t t);
      if (p == 0) begin wr0 = t.wr; addr0 = t.addr; wd0 = t.wd; req0 = 1'b1; end
      else        begin wr1 = t.wr; addr1 = t.addr; wd1 = t.wd; req1 = 1'b1; end
   endtask

   task automatic drop_req(input int p);
      if (p == 0) req0 = 1'b0;
      else        req1 = 1'b0;
   endtask

   // Each port works through its list, re-requesting as soon as the previous
   // four-phase handshake has closed.
   task automatic run_batch(input bit silent);
      txn_t r[2][$];
      txn_t t;
      bit   act[2], seen[2], drp[2];
      logic a, q;
      int   cyc;
      r[0] = pq0;
      r[1] = pq1;
      predict(silent);
      pq0.delete();
      pq1.delete();
      @(negedge CLK);
      for (int p = 0; p < 2; p++) begin
         act[p] = 0; seen[p] = 0; drp[p] = 0;
         if (r[p].size() > 0) begin
            t = r[p].pop_front(); drp[p] = t.drop; drive_port(p, t); act[p] = 1;
         end
      end
      cyc = 0;
      while (act[0] || act[1]) begin
         @(negedge CLK);
         cyc++;
         if (cyc > 3000) begin
            $display("FAIL batch_timeout: got no completion after %0d cycles, required completion", cyc);
            $fatal(1, "batch stalled");
         end
         for (int p = 0; p < 2; p++) begin
            if (act[p]) begin
               a = (p == 0) ? ack0 : ack1;
               q = (p == 0) ? req0 : req1;
               if (a) seen[p] = 1;
               if (q && a) drop_req(p);
               else if (q && drp[p] && busy && mreq && (int'(grant) == p)) drop_req(p);
               q = (p == 0) ? req0 : req1;
               if (seen[p] && !a && !q) begin
                  act[p] = 0;
                  if (r[p].size() > 0) begin
                     t = r[p].pop_front(); drp[p] = t.drop; drive_port(p, t);
                     act[p] = 1; seen[p] = 0;
                  end
               end
            end
         end
      end
   endtask

   function automatic txn_t rnd_txn(input bit drop_ok);
      txn_t t;
      t.wr   = $urandom_range(1, 0) == 1;
      t.addr = AW'($urandom);
      t.wd   = $urandom;
      t.drop = drop_ok && ($urandom_range(3, 0) == 0);
      return t;
   endfunction

   function automatic txn_t mk_txn(input bit wr, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d, input bit drop);
      txn_t t;
      t.wr = wr; t.addr = a; t.wd = d; t.drop = drop;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural memory
   initial begin
      int seen_pulse, lat, b, hold;
      seen_pulse = 0;
      mack = 1'b0; mdin = '0; mw_addr = '0; mw_data = '0;
      forever begin
         @(negedge CLK);
         if (pulse_req_cnt != seen_pulse) begin
            seen_pulse = pulse_req_cnt;
            mack = 1'b1;
            repeat (2) @(negedge CLK);
            mack = 1'b0;
         end else if (mreq && !mem_silent) begin
            lat = $urandom_range(lat_max, lat_min);
            repeat (lat) @(negedge CLK);
            if (mwr) begin
               mdin = $urandom; mw_addr = maout; mw_data = mdout;
            end else begin
               mdin = ovr_en ? ovr_val : hash(maout);
            end
            mack = 1'b1;
            b = 0;
            while (mreq) begin
               @(negedge CLK);
               b++;
               if (b > 100) begin
                  $display("FAIL mem_req_release: got MEM_REQ_OUT=1 after %0d cycles of ack, required 0", b);
                  $fatal(1, "memory request stuck");
               end
            end
            hold = $urandom_range(2, 0);
            repeat (hold) @(negedge CLK);
            mack = 1'b0;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      bit   pa[2], preq, pack_in, rchk;
      bit   ldrop[2];
      int   alen[2];
      int   hi_cnt, hi_last;
      logic a, e_err;
      exp_t e;
      pa[0] = 0; pa[1] = 0; preq = 0; pack_in = 0; rchk = 0;
      ldrop[0] = 0; ldrop[1] = 0; alen[0] = 0; alen[1] = 0;
      hi_cnt = 0; hi_last = 0;
      forever begin
         @(negedge CLK);
         #1;
         if (!rstn) begin
            if (!rchk) begin
               chk("reset_ctrl", {57'd0, ack0, ack1, err0, err1, grant, busy, mreq, mwr}, 64'd0);
               chk("reset_rdata", 64'(rdata), 64'd0);
               chk("reset_aout", 64'(maout), 64'd0);
               chk("reset_dout", 64'(mdout), 64'd0);
               rchk = 1;
            end
            pa[0] = 0; pa[1] = 0; preq = 0; pack_in = 0; hi_cnt = 0;
         end else begin
            rchk = 0;
            if (mreq) begin
               if (!preq) begin
                  chk("issue_with_mem_ack_low", 64'(pack_in), 64'd0);
                  hi_cnt = 0;
               end
               hi_cnt++;
            end else if (preq) begin
               hi_last = hi_cnt;
            end
            for (int p = 0; p < 2; p++) begin
               a     = (p == 0) ? ack0 : ack1;
               e_err = (p == 0) ? err0 : err1;
               if (a && !pa[p]) begin
                  alen[p] = 1;
                  if (sb.size() == 0) begin
                     n_cmp++; n_fail++;
                     $display("FAIL spurious_ack: got ACK%0d rise, required no ack", p);
                     ldrop[p] = 0;
                  end else begin
                     e = sb.pop_front();
                     chk("ack_port", 64'(p), 64'(e.port));
                     chk("grant", 64'(grant), 64'(e.port));
                     chk("err", 64'(e_err), 64'(e.err));
                     chk("rdata", 64'(rdata), 64'(e.rd));
                     chk("mem_write", 64'(mwr), 64'(e.wr));
                     chk("mem_aout", 64'(maout), 64'(e.addr));
                     if (e.wr) chk("mem_dout", 64'(mdout), 64'(e.wd));
                     if (e.wr && !e.err) chk("mem_saw_write", {2'b00, mw_addr, mw_data}, {2'b00, e.addr, e.wd});
                     if (e.err) chk("req_out_cycles", 64'(hi_last), 64'(TO));
                     ldrop[p] = e.drop;
                  end
               end else if (a) begin
                  alen[p]++;
               end else if (pa[p] && ldrop[p]) begin
                  chk("ack_pulse_len", 64'(alen[p]), 64'd1);
               end
               pa[p] = a;
            end
            preq    = mreq;
            pack_in = mack;
         end
      end
   end

   // Stimulus
   initial begin
      int q0, q1;
      n_cmp = 0; n_fail = 0;
      rstn = 1'b0;
      req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
      addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
      m_rdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_pref = 0;
`endif
      mem_silent = 0; lat_min = 0; lat_max = 0;
      ovr_en = 0; ovr_val = '0; pulse_req_cnt = 0;
      repeat (3) @(negedge CLK);
      rstn = 1'b1;

      // port 0 read, memory answers one cycle after the request
      ovr_en = 1; ovr_val = 32'hDEADBEEF;
      pq0.push_back(mk_txn(0, 30'h10, '0, 0));
      run_batch(0);
      ovr_en = 0;

      // port 1 write at the top word address
      lat_max = 4;
      pq1.push_back(mk_txn(1, 30'h3FFFFFFF, 32'hCAFEF00D, 0));
      run_batch(0);

      // both ports requesting back to back
      for (int i = 0; i < 4; i++) pq0.push_back(rnd_txn(0));
      for (int i = 0; i < 2; i++) pq1.push_back(rnd_txn(0));
      run_batch(0);

      // watchdog timeout, then a late memory ack while port 1 requests
      mem_silent = 1;
      pq0.push_back(mk_txn(0, 30'h55, '0, 0));
      run_batch(1);
      mem_silent = 0;
      pulse_req_cnt++;
      pq1.push_back(mk_txn(1, 30'h66, 32'h12345678, 0));
      run_batch(0);

      // reset while an access is outstanding
      mem_silent = 1;
      @(negedge CLK);
      wr1 = 0; addr1 = 30'h77; req1 = 1;
      for (int i = 0; i < 50 && !mreq; i++) @(negedge CLK);
      repeat (2) @(negedge CLK);
      @(posedge CLK);
      #2;
      rstn = 1'b0;
      req1 = 0;
      repeat (3) @(negedge CLK);
      rstn = 1'b1;
      mem_silent = 0;
      m_rdata = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      m_pref = 0;
`endif
      pq1.push_back(mk_txn(0, 30'h78, '0, 0));
      run_batch(0);

      // port 0 abandons its request mid-access, port 1 pending
      pq0.push_back(mk_txn(0, 30'h99, '0, 1));
      pq1.push_back(mk_txn(1, 30'hAA, 32'h0BADF00D, 0));
      run_batch(0);

      // randomized batches
      for (int b = 0; b < 40; b++) begin
         q0 = $urandom_range(3, 0);
         q1 = $urandom_range(3, 0);
         for (int i = 0; i < q0; i++) pq0.push_back(rnd_txn(1));
         for (int i = 0; i < q1; i++) pq1.push_back(rnd_txn(1));
         run_batch(0);
      end

      repeat (5) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
